othello_turn_ctrl: RTL and testbench
====================================

Name: othello_turn_ctrl

Overview:
- Player-facing move sequencer. It sits directly upstream of the board storage/flip stage.
- Owns the cursor (x, y) and the side to move.
- On a place request it pulses the board's detect enable, samples the 8-bit direction mask and, if legal, pulses the write enable. It then hands the turn to the opponent.
- Produces status pulses for the display/score logic.

Parameters:
- DET_WAIT, 3: cycles detecten is held high before dir is sampled (min 2).
- WRITE_WAIT, 2: cycles writeen is held high (min 1).
- TIMEOUT_CYCLES, 50000000: idle cycles before a forced pass (MOVE_TIMEOUT_EN only).

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  synchronous, active-low reset
- btn_left  in  1  one-cycle pulse, cursor x-1
- btn_right  in  1  one-cycle pulse, cursor x+1
- btn_up  in  1  one-cycle pulse, cursor y-1
- btn_down  in  1  one-cycle pulse, cursor y+1
- btn_place  in  1  one-cycle pulse, attempt move at cursor
- dir  in  8  legal-direction mask from board stage (bit0 up, bit2 right, bit4 down, bit6 left; others may be set)
- x  out  3  cursor column, to board
- y  out  3  cursor row, to board
- side  out  2  side to move, 2'd2 or 2'd3, to board
- detecten  out  1  level enable to board detect
- writeen  out  1  level enable to board write
- busy  out  1  high in any state other than IDLE
- illegal  out  1  one-cycle pulse, move rejected
- move_done  out  1  one-cycle pulse, move committed
- move_count  out  7  committed moves, saturates at 127
- timed_out  out  1  one-cycle pulse, forced pass (0 when macro off)

Behaviour:
- Reset (resetn=0 at a clock edge):
  - state=IDLE, x=0, y=0, side=2'd2.
  - detecten=0, writeen=0, all pulses 0, move_count=0, wait counter=0.
  - Reset wins over every concurrent event, including reset mid-DETECT or mid-WRITE: the enables are low the cycle after.
- States: IDLE, DETECT, CHECK, WRITE, SWAP, REJECT.
- IDLE:
  - Cursor pulses update x/y with mod-8 wrap (x=7 +1 gives 0; x=0 -1 gives 7).
  - Several direction pulses in one cycle are applied independently per axis. left+right together cancel; up+down together cancel.
  - btn_place moves to DETECT and clears the wait counter. A cursor pulse in the same cycle as btn_place is ignored; the move uses the pre-existing x/y.
- DETECT:
  - detecten=1 for exactly DET_WAIT cycles, then go to CHECK.
  - x, y, side are frozen from DETECT entry until return to IDLE.
- CHECK (1 cycle):
  - detecten=0.
  - If dir!=0, go to WRITE; otherwise go to REJECT.
- WRITE:
  - writeen=1 for exactly WRITE_WAIT cycles, then go to SWAP.
- SWAP (1 cycle):
  - side toggles (2'd2 and 2'd3 swap).
  - move_count increments unless already 127.
  - move_done=1, then go to IDLE.
- REJECT (1 cycle): illegal=1, side unchanged, then go to IDLE.
- Inputs ignored while busy=1: all btn_* pulses.
- Enable-edge guarantee: detecten and writeen are never high in the same cycle. Each enable is low for at least one cycle between consecutive assertions, because the board edge-detects its enables.
- Latency: btn_place at edge N gives detecten high N+1..N+DET_WAIT and CHECK at N+DET_WAIT+1.
  - Legal: writeen high from N+DET_WAIT+2 for WRITE_WAIT cycles; move_done at N+DET_WAIT+WRITE_WAIT+2.
  - Illegal: illegal at N+DET_WAIT+2.
- Outputs are registered.

Optional Feature:
- Macro: OTHELLO_MOVE_TIMEOUT_EN.
- Defined:
  - A 26-bit idle counter runs in IDLE and clears on any btn_* pulse or on leaving IDLE.
  - On reaching TIMEOUT_CYCLES-1: side toggles, timed_out pulses 1 cycle, counter clears, move_count unchanged.
  - A btn_place in that same cycle takes priority and the timeout is dropped.
- Undefined: no counter is built and timed_out is tied to 0.

Decomposition:
- Shared package othello_pkg:
  - SIDE_BLACK=2'd2, SIDE_WHITE=2'd3, SIDE_EMPTY=2'd0.
  - Direction bit indices DIR_UP=0 .. DIR_UPLEFT=7.
  - State enum type turn_state_t.
- One natural sub-module: cursor_xy, the wrap-around 3-bit x/y counter pair with freeze input.

Test Plan:
- Reset: hold resetn=0 two cycles, release. Expect x=0, y=0, side=2, detecten=0, writeen=0, move_count=0, busy=0.
- Cursor wrap:
  - 3 btn_right pulses: x=3.
  - From x=0, btn_left: x=7.
  - btn_up from y=0: y=7.
  - left+right in the same cycle: x unchanged.
- Illegal move: dir=8'h00, btn_place at N.
  - detecten high N+1..N+3 (DET_WAIT=3).
  - illegal at N+5, side stays 2, move_count 0, writeen never high.
- Legal move: dir=8'h04, btn_place at N.
  - writeen high N+5..N+6.
  - move_done at N+7, side=3, move_count=1.
  - btn_right during busy: x unchanged.
- Reset mid-operation: resetn=0 while writeen=1. Next cycle writeen=0, state IDLE, side=2, move_count=0.
- OTHELLO_MOVE_TIMEOUT_EN with TIMEOUT_CYCLES=10: idle 10 cycles with no input gives a timed_out pulse, side 2 to 3, move_count unchanged. A btn_right at cycle 5 restarts the count.

Source files
------------

// File: rtl/othello_pkg.sv
// Shared constants and state type for the Othello move sequencer and board stage.
package othello_pkg;

    localparam logic [1:0] SIDE_EMPTY = 2'd0;
    localparam logic [1:0] SIDE_BLACK = 2'd2;
    localparam logic [1:0] SIDE_WHITE = 2'd3;

    localparam int DIR_UP        = 0;
    localparam int DIR_UPRIGHT   = 1;
    localparam int DIR_RIGHT     = 2;
    localparam int DIR_DOWNRIGHT = 3;
    localparam int DIR_DOWN      = 4;
    localparam int DIR_DOWNLEFT  = 5;
    localparam int DIR_LEFT      = 6;
    localparam int DIR_UPLEFT    = 7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DETECT = 3'd1,
        CHECK  = 3'd2,
        WRITE  = 3'd3,
        SWAP   = 3'd4,
        REJECT = 3'd5
    } turn_state_t;

    function automatic logic [1:0] other_side(input logic [1:0] s);
        return (s == SIDE_BLACK) ? SIDE_WHITE : SIDE_BLACK;
    endfunction

endpackage

// File: rtl/cursor_xy.sv
// Wrap-around 3-bit cursor pair; opposing pulses on one axis cancel, freeze holds both.
module cursor_xy (
    input  logic       clock,
    input  logic       resetn,
    input  logic       freeze,
    input  logic       inc_x,
    input  logic       dec_x,
    input  logic       inc_y,
    input  logic       dec_y,
    output logic [2:0] x,
    output logic [2:0] y
);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            x <= 3'd0;
            y <= 3'd0;
        end else if (!freeze) begin
            if (inc_x && !dec_x)      x <= x + 3'd1;
            else if (dec_x && !inc_x) x <= x - 3'd1;
            if (inc_y && !dec_y)      y <= y + 3'd1;
            else if (dec_y && !inc_y) y <= y - 3'd1;
        end
    end

endmodule

// File: rtl/othello_turn_ctrl.sv
// Move sequencer: cursor, side to move, detect/write handshake with the board stage.
// Optional forced-pass timer when OTHELLO_MOVE_TIMEOUT_EN is defined.
module othello_turn_ctrl
    import othello_pkg::*;
#(
    parameter int DET_WAIT       = 3,
    parameter int WRITE_WAIT     = 2,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_place,
    input  logic [7:0] dir,
    output logic [2:0] x,
    output logic [2:0] y,
    output logic [1:0] side,
    output logic       detecten,
    output logic       writeen,
    output logic       busy,
    output logic       illegal,
    output logic       move_done,
    output logic [6:0] move_count,
    output logic       timed_out
);

    turn_state_t state;
    logic [7:0]  wcnt;
    logic        unused_timeout;

    assign unused_timeout = ^32'(TIMEOUT_CYCLES);

    // A place pulse locks the cursor in the same cycle so the move uses the old x/y.
    cursor_xy u_cursor (
        .clock (clock),
        .resetn(resetn),
        .freeze(busy | btn_place),
        .inc_x (btn_right),
        .dec_x (btn_left),
        .inc_y (btn_down),
        .dec_y (btn_up),
        .x     (x),
        .y     (y)
    );

`ifdef OTHELLO_MOVE_TIMEOUT_EN
    logic [25:0] idle_cnt;
    logic        any_btn;
    assign any_btn = btn_left | btn_right | btn_up | btn_down | btn_place;
`endif

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= IDLE;
            side       <= SIDE_BLACK;
            detecten   <= 1'b0;
            writeen    <= 1'b0;
            busy       <= 1'b0;
            illegal    <= 1'b0;
            move_done  <= 1'b0;
            move_count <= 7'd0;
            timed_out  <= 1'b0;
            wcnt       <= 8'd0;
`ifdef OTHELLO_MOVE_TIMEOUT_EN
            idle_cnt   <= 26'd0;
`endif
        end else begin
            illegal   <= 1'b0;
            move_done <= 1'b0;
            timed_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_place) begin
                        state <= DETECT;
                        busy  <= 1'b1;
                        wcnt  <= 8'd0;
`ifdef OTHELLO_MOVE_TIMEOUT_EN
                        idle_cnt <= 26'd0;
                    end else if (any_btn) begin
                        idle_cnt <= 26'd0;
                    end else if (idle_cnt == 26'(TIMEOUT_CYCLES - 1)) begin
                        side      <= other_side(side);
                        timed_out <= 1'b1;
                        idle_cnt  <= 26'd0;
                    end else begin
                        idle_cnt <= idle_cnt + 26'd1;
`endif
                    end
                end
                // First DETECT cycle keeps detecten low, giving the board a clean rising edge.
                DETECT: begin
                    if (wcnt == 8'(DET_WAIT)) begin
                        state    <= CHECK;
                        detecten <= 1'b0;
                    end else begin
                        detecten <= 1'b1;
                        wcnt     <= wcnt + 8'd1;
                    end
                end
                CHECK: begin
                    if (dir != 8'd0) begin
                        state   <= WRITE;
                        writeen <= 1'b1;
                        wcnt    <= 8'd1;
                    end else begin
                        state   <= REJECT;
                        illegal <= 1'b1;
                    end
                end
                WRITE: begin
                    if (wcnt == 8'(WRITE_WAIT)) begin
                        state     <= SWAP;
                        writeen   <= 1'b0;
                        side      <= other_side(side);
                        move_done <= 1'b1;
                        if (move_count != 7'd127) move_count <= move_count + 7'd1;
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end
                SWAP, REJECT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_othello_turn_ctrl.sv
// Directed bench for othello_turn_ctrl: reset, cursor wrap, illegal/legal moves, mid-op reset.
module tb_othello_turn_ctrl;

    logic       clock = 1'b0;
    logic       resetn;
    logic       btn_left, btn_right, btn_up, btn_down, btn_place;
    logic [7:0] dir;
    logic [2:0] x, y;
    logic [1:0] side;
    logic       detecten, writeen, busy, illegal, move_done, timed_out;
    logic [6:0] move_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    othello_turn_ctrl #(
        .DET_WAIT      (3),
        .WRITE_WAIT    (2),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_place (btn_place),
        .dir       (dir),
        .x         (x),
        .y         (y),
        .side      (side),
        .detecten  (detecten),
        .writeen   (writeen),
        .busy      (busy),
        .illegal   (illegal),
        .move_done (move_done),
        .move_count(move_count),
        .timed_out (timed_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse(input logic l, input logic r, input logic u, input logic d, input logic p);
        btn_left = l; btn_right = r; btn_up = u; btn_down = d; btn_place = p;
        step();
        btn_left = 0; btn_right = 0; btn_up = 0; btn_down = 0; btn_place = 0;
    endtask

    initial begin
        resetn = 0; dir = 8'h00;
        btn_left = 0; btn_right = 0; btn_up = 0; btn_down = 0; btn_place = 0;
        step(); step();
        resetn = 1;
        step();
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_side", 32'(side), 2);
        chk("rst_detecten", 32'(detecten), 0);
        chk("rst_writeen", 32'(writeen), 0);
        chk("rst_count", 32'(move_count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_move_done", 32'(move_done), 0);
`ifndef OTHELLO_MOVE_TIMEOUT_EN
        chk("rst_timed_out", 32'(timed_out), 0);
`endif

        // cursor movement and wrap
        for (int i = 0; i < 3; i++) pulse(0, 1, 0, 0, 0);
        chk("right3_x", 32'(x), 3);
        for (int i = 0; i < 3; i++) pulse(1, 0, 0, 0, 0);
        chk("left3_x", 32'(x), 0);
        pulse(1, 0, 0, 0, 0);
        chk("left_wrap_x", 32'(x), 7);
        pulse(0, 1, 0, 0, 0);
        chk("right_wrap_x", 32'(x), 0);
        pulse(0, 0, 1, 0, 0);
        chk("up_wrap_y", 32'(y), 7);
        pulse(0, 0, 0, 1, 0);
        chk("down_wrap_y", 32'(y), 0);
        pulse(1, 1, 0, 0, 0);
        chk("lr_cancel_x", 32'(x), 0);
        pulse(0, 0, 1, 1, 0);
        chk("ud_cancel_y", 32'(y), 0);
        pulse(0, 1, 0, 1, 0);
        chk("diag_x", 32'(x), 1);
        chk("diag_y", 32'(y), 1);

        // illegal move, place at edge N
        dir = 8'h00;
        pulse(0, 0, 0, 0, 1);
        chk("ill_N_busy", 32'(busy), 1);
        chk("ill_N_detecten", 32'(detecten), 0);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("ill_det_N+%0d", k), 32'(detecten), 1);
            chk("ill_no_writeen", 32'(writeen), 0);
        end
        step();
        chk("ill_N+4_detecten", 32'(detecten), 0);
        chk("ill_N+4_illegal", 32'(illegal), 0);
        step();
        chk("ill_N+5_illegal", 32'(illegal), 1);
        chk("ill_N+5_writeen", 32'(writeen), 0);
        chk("ill_side", 32'(side), 2);
        chk("ill_count", 32'(move_count), 0);
        step();
        chk("ill_N+6_illegal", 32'(illegal), 0);
        chk("ill_N+6_busy", 32'(busy), 0);

        // legal move; cursor pulse in the place cycle and while busy are ignored
        dir = 8'h04;
        pulse(0, 1, 0, 0, 1);
        chk("leg_place_x", 32'(x), 1);
        step();
        pulse(0, 1, 0, 0, 0);
        chk("leg_busy_x", 32'(x), 1);
        step();
        chk("leg_N+3_detecten", 32'(detecten), 1);
        step();
        chk("leg_N+4_detecten", 32'(detecten), 0);
        chk("leg_N+4_writeen", 32'(writeen), 0);
        step();
        chk("leg_N+5_writeen", 32'(writeen), 1);
        chk("leg_N+5_detecten", 32'(detecten), 0);
        step();
        chk("leg_N+6_writeen", 32'(writeen), 1);
        chk("leg_N+6_move_done", 32'(move_done), 0);
        step();
        chk("leg_N+7_writeen", 32'(writeen), 0);
        chk("leg_N+7_move_done", 32'(move_done), 1);
        chk("leg_side", 32'(side), 3);
        chk("leg_count", 32'(move_count), 1);
        step();
        chk("leg_N+8_move_done", 32'(move_done), 0);
        chk("leg_N+8_busy", 32'(busy), 0);
        chk("leg_x_kept", 32'(x), 1);

        // second legal move with a diagonal-only mask hands the turn back
        dir = 8'h80;
        pulse(0, 0, 0, 0, 1);
        for (int k = 1; k <= 7; k++) step();
        chk("leg2_move_done", 32'(move_done), 1);
        chk("leg2_side", 32'(side), 2);
        chk("leg2_count", 32'(move_count), 2);
        step();

        // reset while writeen is high
        dir = 8'h01;
        pulse(0, 0, 0, 0, 1);
        for (int k = 1; k <= 5; k++) step();
        chk("mid_writeen_pre", 32'(writeen), 1);
        resetn = 0;
        step();
        chk("mid_writeen", 32'(writeen), 0);
        chk("mid_detecten", 32'(detecten), 0);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_side", 32'(side), 2);
        chk("mid_count", 32'(move_count), 0);
        chk("mid_x", 32'(x), 0);
        resetn = 1;
        step();
        chk("mid_after_busy", 32'(busy), 0);
        chk("mid_after_move_done", 32'(move_done), 0);

`ifdef OTHELLO_MOVE_TIMEOUT_EN
        resetn = 0;
        step();
        resetn = 1;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("to_early", 32'(timed_out), 0);
        end
        pulse(0, 1, 0, 0, 0);
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("to_restart", 32'(timed_out), 0);
        end
        step();
        chk("to_pulse", 32'(timed_out), 1);
        chk("to_side", 32'(side), 3);
        chk("to_count", 32'(move_count), 0);
        step();
        chk("to_pulse_end", 32'(timed_out), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
